uart_rx: RTL and testbench
==========================

# uart_rx

- Serial receiver for 8N1 frames at a fixed integer clocks-per-bit rate: idle high, start bit 0, 8 data bits LSB first, one stop bit 1.
- Synchronises the asynchronous line, validates the start bit and samples each bit at mid-period.
- Delivers each byte through a one-entry valid/ready output register, with framing and overrun flags.
- Sits directly downstream of the UART transmitter on the serial link and feeds byte consumers (command parser, FIFO).

## Interface
- clocks_per_bit, default 4: clk cycles per serial bit; legal ≥2 (≥4 with UART_RX_MAJORITY_EN).
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_rx  in  1  serial line, asynchronous to clk.
- in_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  8  received byte; stable while out_valid.
- out_valid  out  1  out_data holds an unconsumed byte.
- out_busy  out  1  high in any state other than IDLE.
- out_error  out  1  one-cycle pulse: stop bit sampled 0.
- out_overrun  out  1  one-cycle pulse: byte completed while the output register was still full.

## Operation
- Synchroniser: 2 flops, both reset to 1; rx_s is the second flop. No logic reads in_rx directly.
- Counters:
  - cycle_count is $clog2(clocks_per_bit) bits wide.
  - bit_index is 3 bits.
  - shift register is 8 bits; bits enter at bit 7 and shift right.
- Sample tick: in any state except IDLE and RECOVER, if cycle_count≠0 it decrements; otherwise it is a sample cycle and cycle_count reloads clocks_per_bit-1.
- States:
  - IDLE: when rx_s==0, go to START and load cycle_count=clocks_per_bit/2-1.
  - START: on the sample cycle, if the sample is 0 go to DATA with bit_index=0. If the sample is 1 it is a false start: return to IDLE with no flag.
  - DATA: on each sample cycle shift the sample in and increment bit_index. After the sample at bit_index 7, go to STOP.
  - STOP: on the sample cycle, if the sample is 1, deliver the byte and go to IDLE. If the sample is 0, pulse out_error, discard the byte and go to RECOVER.
  - RECOVER: wait until rx_s==1, then go to IDLE. This is break/low-line protection.
- Delivery:
  - If out_valid==0, or out_valid && in_ready in the same cycle: out_data is loaded and out_valid=1 next cycle.
  - If out_valid && !in_ready: the new byte is dropped, the old byte is kept, and out_overrun pulses.
- Consumption: out_valid && in_ready with no simultaneous delivery clears out_valid next cycle.
- Reset, including mid-frame: state IDLE, partial byte discarded, counters 0, sync flops 1.
- Output reset values: out_data=0, out_valid=0, out_busy=0, out_error=0, out_overrun=0.

## Timing
- Let T be the cycle in_rx first goes low. rx_s goes low at T+2 and the FSM leaves IDLE at T+3.
- Start sample at T+2+clocks_per_bit/2.
- Data bit k sample at start sample + (k+1)·clocks_per_bit.
- Stop sample at start sample + 9·clocks_per_bit.
- out_valid rises the cycle after the stop sample. With clocks_per_bit=4: start sample T+4, d0 at T+8, stop at T+40, out_valid at T+41.
- Returning to IDLE at the stop mid-point lets the receiver catch back-to-back frames whose next start bit follows the stop bit immediately.
- out_error and out_overrun are high for exactly one cycle, in the cycle after the stop sample.
- out_busy falls the cycle after the stop sample (or after RECOVER exits).
- Throughput: one byte per 10·clocks_per_bit cycles.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - A 3-entry history of rx_s is kept.
  - Every sample (start, data, stop) is the majority of rx_s at the sample cycle and the two cycles before it.
  - clocks_per_bit ≥4 is required.
- Undefined: the sample is rx_s at the sample cycle only, and there is no history register.
- Timing of all outputs is identical in both builds.

## Test plan
- clocks_per_bit=4, frame 0xA5 with in_ready=1 held, in_rx first low at T → out_valid=1 at T+41 for exactly one cycle, out_data=0xA5, out_error=0, out_overrun=0.
- Frames 0x00 then 0xFF back-to-back (no idle gap), in_ready=1 → two valid pulses 40 cycles apart, data 0x00 then 0xFF.
- Frame 0x3C with stop bit driven 0 and the line held low 20 more cycles → out_error pulse at T+41, no out_valid, out_busy stays high until 3 cycles after the line returns high.
- in_rx low for 1 cycle only → start sample is 1, no flags, FSM back in IDLE. With UART_RX_MAJORITY_EN, a 1-cycle glitch inside data bit 3 of 0x00 still yields 0x00.
- in_ready=0, frames 0x11 then 0x22 → out_data stays 0x11, out_overrun pulses at the second stop, then in_ready=1 clears out_valid.
- rst_n asserted mid-frame after 0x5A bit 4, then a full 0x5A frame → no output from the partial frame, then out_data=0x5A.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with a fixed integer number of clk cycles per bit.
// The asynchronous line is brought into the clk domain through two flops. A
// falling edge is qualified by a start-bit sample at its mid-period, and every
// following bit is sampled at its mid-period. Completed bytes are handed over
// through a one-entry valid/ready register. Framing and overrun events are
// reported as one-cycle pulses.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN - every sample is the 2-of-3 majority of rx_s over the
//                         sample cycle and the two cycles before it. This
//                         requires clocks_per_bit >= 4. Output timing is the
//                         same as in the default build.
//
// Parameter:
//   clocks_per_bit - clk cycles per serial bit (>= 2, or >= 4 with majority)
//
// Ports:
//   clk         in   clock, all state updates on posedge
//   rst_n       in   asynchronous active-low reset
//   in_rx       in   serial line, asynchronous to clk, idle high
//   in_ready    in   consumer takes out_data this cycle
//   out_data    out  [7:0] received byte, stable while out_valid
//   out_valid   out  out_data holds an unconsumed byte
//   out_busy    out  receiver is in any state other than IDLE
//   out_error   out  one-cycle pulse when the stop bit is sampled 0
//   out_overrun out  one-cycle pulse when a byte completes while the output
//                    register is still full (the new byte is dropped)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int clocks_per_bit = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_rx,
    input  logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_busy,
    output logic       out_error,
    output logic       out_overrun
);

    localparam int CW = (clocks_per_bit > 2) ? $clog2(clocks_per_bit) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(clocks_per_bit - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(clocks_per_bit / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    logic [1:0]    sync_r;
    logic          rx_s;
    logic          sample_s;
    logic          tick_s;
    logic          counting_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [2:0]    idx_r;
    logic [2:0]    idx_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic [7:0]    data_nxt_s;
    logic          valid_nxt_s;
    logic          busy_nxt_s;
    logic          error_nxt_s;
    logic          overrun_nxt_s;
    logic          deliver_s;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], in_rx};
        end
    end

    assign rx_s = sync_r[1];

`ifdef UART_RX_MAJORITY_EN
    // 2-of-3 vote used to reject single-cycle glitches on the line.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] hist_r;   // [0] = rx_s one cycle ago, [1] = two cycles ago

    // Short history of the synchronised line for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = maj3(rx_s, hist_r[0], hist_r[1]);
`else
    assign sample_s = rx_s;
`endif

    // The bit-period counter only runs while a frame is being received.
    assign counting_s = (state_r == ST_START) || (state_r == ST_DATA) ||
                        (state_r == ST_STOP);
    assign tick_s     = counting_s && (cnt_r == '0);

    // State register and datapath/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            out_busy    <= 1'b0;
            out_error   <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            shift_r     <= shift_nxt_s;
            out_data    <= data_nxt_s;
            out_valid   <= valid_nxt_s;
            out_busy    <= busy_nxt_s;
            out_error   <= error_nxt_s;
            out_overrun <= overrun_nxt_s;
        end
    end

    // Next-state, counter, shift and delivery logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        idx_nxt_s     = idx_r;
        shift_nxt_s   = shift_r;
        data_nxt_s    = out_data;
        valid_nxt_s   = out_valid;
        error_nxt_s   = 1'b0;
        overrun_nxt_s = 1'b0;
        deliver_s     = 1'b0;

        if (counting_s) begin
            cnt_nxt_s = tick_s ? CNT_FULL : (cnt_r - CW'(1));
        end else begin
            cnt_nxt_s = cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    // First sample lands half a bit in, at the start-bit centre.
                    state_nxt_s = ST_START;
                    cnt_nxt_s   = CNT_HALF;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (!sample_s) begin
                        state_nxt_s = ST_DATA;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        // Line was high again at mid-bit: glitch, not a frame.
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_nxt_s = {sample_s, shift_r[7:1]};
                    idx_nxt_s   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (sample_s) begin
                        // Leaving at the stop mid-point allows back-to-back frames.
                        deliver_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        error_nxt_s = 1'b1;
                        state_nxt_s = ST_RECOVER;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_RECOVER: begin
                // Hold off until a break / stuck-low line releases.
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RECOVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A slot is free if empty or being drained in this same cycle.
        if (deliver_s) begin
            if (!out_valid || in_ready) begin
                data_nxt_s  = shift_r;
                valid_nxt_s = 1'b1;
            end else begin
                overrun_nxt_s = 1'b1;
            end
        end else if (out_valid && in_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = out_valid;
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx with clocks_per_bit = 4. Frames are driven one
// clk cycle at a time; outputs are observed on the falling edge and summarised
// (valid rise cycles and bytes, error/overrun pulses, busy window) so that
// expected cycle numbers can be written relative to the cycle T in which
// in_rx first goes low.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       in_rx;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_busy;
    logic       out_error;
    logic       out_overrun;

    uart_rx #(.clocks_per_bit(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_rx       (in_rx),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_busy    (out_busy),
        .out_error   (out_error),
        .out_overrun (out_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc;
    int vcnt, ecnt, ocnt, ecyc, ocyc, brise, blast;
    logic pv, pb;
    int   rise_q[$];
    logic [7:0] data_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        vcnt = 0; ecnt = 0; ocnt = 0;
        ecyc = -1; ocyc = -1; brise = -1; blast = -1;
        rise_q.delete();
        data_q.delete();
    endtask

    // Record the outputs of the current cycle, then move to the next cycle.
    task automatic next_cycle();
        @(negedge clk);
        if (out_valid) begin
            vcnt++;
            if (!pv) begin
                rise_q.push_back(cyc);
                data_q.push_back(out_data);
            end
        end
        pv = out_valid;
        if (out_error) begin ecnt++; ecyc = cyc; end
        if (out_overrun) begin ocnt++; ocyc = cyc; end
        if (out_busy) begin
            if (!pb) brise = cyc;
            blast = cyc;
        end
        pb = out_busy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_rx = 1'b1;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // Drive the first len cycles of an 8N1 frame; glitch inverts one cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch, input int len);
        int   b;
        logic v;
        for (int i = 0; i < len; i++) begin
            b = i / CPB;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = d[b-1];
            else             v = stop;
            if (i == glitch) v = ~v;
            in_rx = v;
            next_cycle();
        end
    endtask

    function automatic int rise_at(input int k);
        rise_at = (rise_q.size() > k) ? rise_q[k] : -1;
    endfunction

    function automatic logic [7:0] data_at(input int k);
        data_at = (data_q.size() > k) ? data_q[k] : 8'hxx;
    endfunction

    int t;

    initial begin
        rst_n = 1'b0; in_rx = 1'b1; in_ready = 1'b1;
        pv = 1'b0; pb = 1'b0; cyc = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",    32'(out_data),    32'h00);
        chk("rst_valid",   32'(out_valid),   32'h0);
        chk("rst_busy",    32'(out_busy),    32'h0);
        chk("rst_error",   32'(out_error),   32'h0);
        chk("rst_overrun", 32'(out_overrun), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Single frame 0xA5, consumer always ready.
        clear_mon(); t = cyc;
        send_frame(8'hA5, 1'b1, -1, 40);
        idle(10);
        chk("a5_rise",     32'(rise_at(0)), 32'(t + 41));
        chk("a5_data",     32'(data_at(0)), 32'hA5);
        chk("a5_vcnt",     32'(vcnt),       32'd1);
        chk("a5_err",      32'(ecnt),       32'd0);
        chk("a5_ovr",      32'(ocnt),       32'd0);
        chk("a5_busy_on",  32'(brise),      32'(t + 3));
        chk("a5_busy_off", 32'(blast),      32'(t + 40));

        // Back-to-back 0x00 then 0xFF with no idle gap.
        clear_mon(); t = cyc;
        send_frame(8'h00, 1'b1, -1, 40);
        send_frame(8'hFF, 1'b1, -1, 40);
        idle(10);
        chk("b2b_rise0", 32'(rise_at(0)), 32'(t + 41));
        chk("b2b_rise1", 32'(rise_at(1)), 32'(t + 81));
        chk("b2b_data0", 32'(data_at(0)), 32'h00);
        chk("b2b_data1", 32'(data_at(1)), 32'hFF);
        chk("b2b_err",   32'(ecnt),       32'd0);

        // Framing error: 0x3C with stop 0, line low 20 more cycles.
        clear_mon(); t = cyc;
        send_frame(8'h3C, 1'b0, -1, 40);
        in_rx = 1'b0;
        for (int i = 0; i < 20; i++) next_cycle();
        idle(10);
        chk("fe_err_cnt",  32'(ecnt), 32'd1);
        chk("fe_err_cyc",  32'(ecyc), 32'(t + 41));
        chk("fe_vcnt",     32'(vcnt), 32'd0);
        chk("fe_busy_off", 32'(blast), 32'(t + 62));

        // One-cycle low glitch: false start.
        clear_mon(); t = cyc;
        in_rx = 1'b0;
        next_cycle();
        idle(10);
        chk("fs_vcnt",     32'(vcnt),     32'd0);
        chk("fs_err",      32'(ecnt),     32'd0);
        chk("fs_busy_off", 32'(blast),    32'(t + 4));
        chk("fs_idle",     32'(out_busy), 32'h0);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle high glitch inside data bit 3 of 0x00 is voted out.
        clear_mon(); t = cyc;
        send_frame(8'h00, 1'b1, 18, 40);
        idle(10);
        chk("mj_rise", 32'(rise_at(0)), 32'(t + 41));
        chk("mj_data", 32'(data_at(0)), 32'h00);
`endif

        // Overrun: consumer stalled, 0x11 then 0x22.
        clear_mon(); t = cyc;
        in_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, 40);
        send_frame(8'h22, 1'b1, -1, 40);
        idle(10);
        chk("ov_rise",    32'(rise_at(0)), 32'(t + 41));
        chk("ov_first",   32'(data_at(0)), 32'h11);
        chk("ov_cnt",     32'(ocnt),       32'd1);
        chk("ov_cyc",     32'(ocyc),       32'(t + 81));
        chk("ov_valid",   32'(out_valid),  32'h1);
        chk("ov_kept",    32'(out_data),   32'h11);
        in_ready = 1'b1;
        next_cycle();
        chk("ov_drained", 32'(out_valid),  32'h0);
        idle(4);

        // Reset after bit 4 of 0x5A, then a full 0x5A frame.
        clear_mon();
        send_frame(8'h5A, 1'b1, -1, 24);
        rst_n = 1'b0; in_rx = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        idle(50);
        chk("mr_vcnt", 32'(vcnt),     32'd0);
        chk("mr_err",  32'(ecnt),     32'd0);
        chk("mr_busy", 32'(out_busy), 32'h0);
        chk("mr_data", 32'(out_data), 32'h00);
        clear_mon(); t = cyc;
        send_frame(8'h5A, 1'b1, -1, 40);
        idle(10);
        chk("mr_rise",  32'(rise_at(0)), 32'(t + 41));
        chk("mr_frame", 32'(data_at(0)), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
